// File: rtl/load_unit_if.sv
// ============================================================================
// Module      : load_unit_if
// Description : Data-memory read channel between the load unit and memory.
//               Carries a valid/ready request (word address) and a valid-only
//               read response.
// Ports       : (interface signals)
//               mem_req_valid  - request valid, driven by the master
//               mem_req_addr   - word-aligned request address, master
//               mem_req_ready  - request accepted, driven by the slave
//               mem_rsp_valid  - read data valid, slave
//               mem_rsp_data   - read word (little-endian), slave
// Modports    : master (load unit side), slave (memory side)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_unit_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/load_unit.sv
// ============================================================================
// Module      : load_unit
// Description : Multi-cycle load engine. A start pulse in IDLE issues a
//               word-aligned read, waits for the response, then extracts and
//               sign/zero-extends the addressed byte, halfword or word.
//               Misaligned or illegal loads raise a one-cycle error instead.
// Ports       : clock   - rising-edge clock
//               reset   - asynchronous active-low reset
//               start   - load request pulse (sampled only in IDLE)
//               addr    - byte address of the load
//               funct3  - load type (LB/LH/LW/LBU/LHU)
//               busy    - high whenever not IDLE
//               done    - one-cycle pulse, result valid
//               error   - one-cycle pulse: misaligned, illegal funct3, timeout
//               result  - extended load data, held until the next done
//               mem     - load_unit_if.master read channel
// Parameters  : TIMEOUT_CYCLES - maximum WAIT cycles (1..65535)
// Macro       : LOAD_TIMEOUT_EN - when defined, WAIT is bounded by
//               TIMEOUT_CYCLES and expiry reports error
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  load_unit_if.master mem
);

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Elaboration-time guard on the timeout range.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
    $error("load_unit: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;   // only the byte offset is needed after REQ
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;

`ifdef LOAD_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  logic        w_bad_load;
  logic [31:0] w_load_data;

  // Reject misaligned halfword/word loads and undefined funct3 encodings
  // before any memory traffic is generated.
  always_comb begin
    w_bad_load = 1'b0;
    case (funct3)
      c_LB, c_LBU: w_bad_load = 1'b0;
      c_LH, c_LHU: w_bad_load = addr[0];
      c_LW:        w_bad_load = (addr[1:0] != 2'b00);
      default:     w_bad_load = 1'b1;
    endcase
  end

  // Lane select and extension of the returned word.
  always_comb begin
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    w_byte      = mem.mem_rsp_data[{addr_lo_q, 3'b000} +: 8];
    w_half      = mem.mem_rsp_data[{addr_lo_q[1], 4'b0000} +: 16];
    w_load_data = mem.mem_rsp_data;
    case (funct3_q)
      c_LB:    w_load_data = {{24{w_byte[7]}}, w_byte};
      c_LBU:   w_load_data = {24'd0, w_byte};
      c_LH:    w_load_data = {{16{w_half[15]}}, w_half};
      c_LHU:   w_load_data = {16'd0, w_half};
      default: w_load_data = mem.mem_rsp_data;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    result_d    = result_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
`ifdef LOAD_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_lo_d = addr[1:0];
          funct3_d  = funct3;
          if (w_bad_load) begin
            error_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = {addr[31:2], 2'b00};
          end
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
`ifdef LOAD_TIMEOUT_EN
          cnt_d       = 16'd0;
`endif
        end
      end
      S_WAIT: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (mem.mem_rsp_valid) begin
          result_d = w_load_data;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (cnt_q == c_TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d     = S_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    // busy tracks the state being entered so it drops with done/error.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      result_q    <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'd0;
`ifdef LOAD_TIMEOUT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      result_q    <= result_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
`ifdef LOAD_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign result            = result_q;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_addr  = req_addr_q;

endmodule

`default_nettype wire
